spike_gen_scheduler: RTL and testbench
======================================

Name: spike_gen_scheduler

Overview:
Sequencer for the FPGA spike generator bank. Holds per-generator period/countdown/tag state, programmed through the spike-generator programming channel. On every wall-clock time-unit pulse it sweeps generators 0..gens_used. For each enabled generator whose countdown expires, it emits one tag/count word toward the BD tag router. Sits between the PC-side decoder/time manager and the downstream tag-count merge.

Parameters:
Ngens, 8, generator index width; 2**Ngens generator slots
Nperiod, 16, period/ticks width in time units
Ntag, 11, output tag width
Nct, 9, output count width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
time_unit_pulse  in  1  one-cycle strobe from time manager, once per time unit
gens_used  in  Ngens  highest generator index swept (conf register)
gens_en  in  2**Ngens  per-generator enable (conf register)
prog_gen_idx  in  Ngens  generator slot to program
prog_period  in  Nperiod  emission period in time units; 0 = generator idle
prog_ticks  in  Nperiod  initial countdown value
prog_tag  in  Ntag  tag emitted by this generator
prog_v  in  1  programming word valid
prog_a  out  1  programming word accepted
out_tag  out  Ntag  emitted tag
out_ct  out  Nct  emitted count (always 1)
out_v  out  1  output valid
out_a  in  1  downstream ack
missed_unit  out  1  one-cycle pulse when a time-unit pulse is dropped

Behaviour:
- Clocking/reset: one clock, clk; reset is synchronous and active-high.
- Reset effects: state=IDLE; pending=0; idx=0; out_v=0; out_tag=0; out_ct=0; missed_unit=0.
- Reset clears all slot memory: period=0, ticks=0, tag=0.
- Reset mid-sweep or mid-emit abandons the sweep and drops any held output word.
- Slot memory: 2**Ngens entries of {period, ticks, tag}. Registers or a single-port RAM with 1-cycle read are both acceptable; latency figures below assume registers.
- prog_a: combinational; equals (state==IDLE && !pending && !reset).
- Programming: a word transfers when prog_v && prog_a. That slot's period, ticks and tag are all overwritten in the same cycle.
- Programming is never accepted during a sweep. A prog_v held during a sweep stalls until IDLE.
- Pending flag: set by time_unit_pulse in any state except an IDLE cycle where the pulse starts a sweep directly. Cleared when a sweep starts from it.
- Missed pulses: a time_unit_pulse arriving while pending is already 1 is dropped. missed_unit pulses high the following cycle.
- Pulse and programming in the same IDLE cycle: the programming write completes in that cycle. The sweep starts next cycle and sees the new values.
- State IDLE: on time_unit_pulse or pending, go to SCAN with idx=0.
- State SCAN: evaluate slot idx in one cycle.
  - Slot is active when gens_en[idx]=1 and period!=0.
  - Inactive slot: no memory change.
  - Active with ticks!=0: ticks <= ticks-1.
  - Active with ticks==0: ticks <= period-1; register out_tag=tag[idx], out_ct=1, out_v=1; go to EMIT.
  - Slot not emitting: if idx==gens_used go to IDLE, else idx+1 and stay in SCAN.
- State EMIT: hold out_v, out_tag and out_ct stable until out_a.
  - On the out_a cycle, out_v drops next cycle.
  - Then advance idx, or go to IDLE if idx==gens_used.
  - out_a while out_v=0 is ignored.
- Latency: pulse in IDLE at cycle t → slot 0 evaluated at t+1 → earliest out_v at t+2.
- Sweep length: no-emission sweep takes gens_used+1 cycles. Each emission adds ≥1 cycle.
- Emission rate: a generator with period P and ticks T emits on time units T, T+P, T+2P, … counted from programming. Period 1 emits every time unit.
- Config timing: gens_used and gens_en are sampled live each SCAN cycle, not latched per sweep.
- Arithmetic: period-1 computed in Nperiod bits. Only executed when period!=0, so never underflows.
- idx comparison is equality against gens_used. gens_used=2**Ngens-1 sweeps all slots; idx never wraps past it.

Test Plan:
- Reset, then program gen 3 with period=4, ticks=0, tag=0x155; gens_used=3, gens_en[3]=1; pulse 10 units with out_a tied 1 → tag 0x155, ct=1 emitted on units 1,5,9 only.
- Program gens 0,1,2 with period=1, tags 0x10/0x11/0x12; gens_used=2; all enabled; one pulse → three words in order 0x10,0x11,0x12. First out_v at t+2.
- Same as above with out_a held 0 for 5 cycles → first word held stable 5 cycles, no loss or reordering. A second pulse during the stall sets pending; a third pulse asserts missed_unit once.
- Program gen 0 period=0, and gen 1 period=2 with gens_en[1]=0 → no output over 6 pulses; gen 1 ticks unchanged.
- Assert prog_v during a sweep → prog_a=0 until IDLE; write lands afterward. Pulse and prog in the same IDLE cycle → sweep uses the new values.
- Assert reset while in EMIT with out_v=1 → next cycle out_v=0, prog_a=1, all slot periods 0.

Source files
------------

// File: rtl/spike_gen_scheduler.sv
// Spike generator sequencer: per-slot period/countdown/tag memory, swept once per
// time unit, emitting one tag/count word per expiring generator toward the tag router.
module spike_gen_scheduler #(
  parameter int Ngens   = 8,
  parameter int Nperiod = 16,
  parameter int Ntag    = 11,
  parameter int Nct     = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  time_unit_pulse,
  input  logic [Ngens-1:0]      gens_used,
  input  logic [2**Ngens-1:0]   gens_en,
  input  logic [Ngens-1:0]      prog_gen_idx,
  input  logic [Nperiod-1:0]    prog_period,
  input  logic [Nperiod-1:0]    prog_ticks,
  input  logic [Ntag-1:0]       prog_tag,
  input  logic                  prog_v,
  output logic                  prog_a,
  output logic [Ntag-1:0]       out_tag,
  output logic [Nct-1:0]        out_ct,
  output logic                  out_v,
  input  logic                  out_a,
  output logic                  missed_unit
);

  localparam int NSLOTS = 2**Ngens;
  localparam logic [Ngens-1:0]   IDX_ZERO = {Ngens{1'b0}};
  localparam logic [Ngens-1:0]   IDX_ONE  = {{(Ngens-1){1'b0}}, 1'b1};
  localparam logic [Nperiod-1:0] PER_ZERO = {Nperiod{1'b0}};
  localparam logic [Nperiod-1:0] PER_ONE  = {{(Nperiod-1){1'b0}}, 1'b1};
  localparam logic [Ntag-1:0]    TAG_ZERO = {Ntag{1'b0}};
  localparam logic [Nct-1:0]     CT_ZERO  = {Nct{1'b0}};
  localparam logic [Nct-1:0]     CT_ONE   = {{(Nct-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [Ngens-1:0]   r_idx;
  logic [Ngens-1:0]   w_idx_nxt;
  logic               r_pending;
  logic               w_pending_nxt;
  logic               r_missed;

  logic [Nperiod-1:0] r_period [NSLOTS];
  logic [Nperiod-1:0] r_ticks  [NSLOTS];
  logic [Ntag-1:0]    r_tag    [NSLOTS];

  logic               r_out_v;
  logic [Ntag-1:0]    r_out_tag;
  logic [Nct-1:0]     r_out_ct;

  logic [Nperiod-1:0] w_cur_period;
  logic [Nperiod-1:0] w_cur_ticks;
  logic               w_active;
  logic               w_last;
  logic               w_prog_we;
  logic               w_fire;
  logic               w_dec;

  assign w_cur_period = r_period[r_idx];
  assign w_cur_ticks  = r_ticks[r_idx];
  assign w_active     = gens_en[r_idx] && (w_cur_period != PER_ZERO);
  assign w_last       = (r_idx == gens_used);

  assign prog_a    = (r_state == ST_IDLE) && !r_pending && !reset;
  assign w_prog_we = prog_v && prog_a;

  assign out_v       = r_out_v;
  assign out_tag     = r_out_tag;
  assign out_ct      = r_out_ct;
  assign missed_unit = r_missed;

  // Sequencer state, sweep index and pending-unit bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= IDX_ZERO;
      r_pending <= 1'b0;
      r_missed  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_pending <= w_pending_nxt;
      r_missed  <= time_unit_pulse && r_pending;
    end
  end

  // Next-state decode; pending is only ever cleared by a sweep starting from IDLE
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_pending_nxt = r_pending || time_unit_pulse;
    w_fire        = 1'b0;
    w_dec         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pending_nxt = 1'b0;
        if (time_unit_pulse || r_pending) begin
          w_state_nxt = ST_SCAN;
          w_idx_nxt   = IDX_ZERO;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (w_active && (w_cur_ticks == PER_ZERO)) begin
          w_fire      = 1'b1;
          w_state_nxt = ST_EMIT;
        end else begin
          w_dec = w_active;
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = IDX_ZERO;
          end else begin
            w_idx_nxt = r_idx + IDX_ONE;
          end
        end
      end
      ST_EMIT: begin
        if (out_a && r_out_v) begin
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = IDX_ZERO;
          end else begin
            w_state_nxt = ST_SCAN;
            w_idx_nxt   = r_idx + IDX_ONE;
          end
        end else begin
          w_state_nxt = ST_EMIT;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_idx_nxt     = IDX_ZERO;
        w_pending_nxt = 1'b0;
      end
    endcase
  end

  // Slot memory: programming only happens in IDLE, countdown updates only in SCAN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSLOTS; i++) begin
        r_period[i] <= PER_ZERO;
        r_ticks[i]  <= PER_ZERO;
        r_tag[i]    <= TAG_ZERO;
      end
    end else begin
      if (w_prog_we) begin
        r_period[prog_gen_idx] <= prog_period;
        r_ticks[prog_gen_idx]  <= prog_ticks;
        r_tag[prog_gen_idx]    <= prog_tag;
      end
      if (w_fire) begin
        r_ticks[r_idx] <= w_cur_period - PER_ONE;
      end else if (w_dec) begin
        r_ticks[r_idx] <= w_cur_ticks - PER_ONE;
      end
    end
  end

  // Output word register, held stable until the downstream ack
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_v   <= 1'b0;
      r_out_tag <= TAG_ZERO;
      r_out_ct  <= CT_ZERO;
    end else if (w_fire) begin
      r_out_v   <= 1'b1;
      r_out_tag <= r_tag[r_idx];
      r_out_ct  <= CT_ONE;
    end else if ((r_state == ST_EMIT) && out_a) begin
      r_out_v <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spike_gen_scheduler.sv
// Directed self-checking bench for spike_gen_scheduler.
module tb_spike_gen_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic         time_unit_pulse;
  logic [7:0]   gens_used;
  logic [255:0] gens_en;
  logic [7:0]   prog_gen_idx;
  logic [15:0]  prog_period;
  logic [15:0]  prog_ticks;
  logic [10:0]  prog_tag;
  logic         prog_v;
  logic         prog_a;
  logic [10:0]  out_tag;
  logic [8:0]   out_ct;
  logic         out_v;
  logic         out_a;
  logic         missed_unit;

  int n_checks = 0;
  int n_fail   = 0;
  int n_missed = 0;
  logic [10:0] q_tag[$];
  logic [8:0]  q_ct[$];

  spike_gen_scheduler dut (
    .clk(clk), .reset(reset), .time_unit_pulse(time_unit_pulse),
    .gens_used(gens_used), .gens_en(gens_en),
    .prog_gen_idx(prog_gen_idx), .prog_period(prog_period), .prog_ticks(prog_ticks),
    .prog_tag(prog_tag), .prog_v(prog_v), .prog_a(prog_a),
    .out_tag(out_tag), .out_ct(out_ct), .out_v(out_v), .out_a(out_a),
    .missed_unit(missed_unit)
  );

  always #5 clk = ~clk;

  // Record every accepted output word and every missed-unit pulse
  always @(posedge clk) begin
    if (!reset && out_v && out_a) begin
      q_tag.push_back(out_tag);
      q_ct.push_back(out_ct);
    end
    if (!reset && missed_unit) n_missed++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; time_unit_pulse = 1'b0; prog_v = 1'b0; out_a = 1'b1;
    gens_used = 8'd0; gens_en = '0;
    prog_gen_idx = 8'd0; prog_period = 16'd0; prog_ticks = 16'd0; prog_tag = 11'd0;
    tick; tick;
    reset = 1'b0;
    q_tag.delete(); q_ct.delete(); n_missed = 0;
  endtask

  task automatic prog(input logic [7:0] idx, input logic [15:0] per,
                      input logic [15:0] tk, input logic [10:0] tg);
    int n;
    prog_gen_idx = idx; prog_period = per; prog_ticks = tk; prog_tag = tg;
    prog_v = 1'b1;
    n = 0;
    while (!prog_a && n < 600) begin tick; n++; end
    n_checks++;
    if (prog_a !== 1'b1) begin n_fail++; $display("FAIL prog_timeout: prog_a=%b expected 1", prog_a); end
    tick;
    prog_v = 1'b0;
  endtask

  task automatic pulse;
    time_unit_pulse = 1'b1;
    tick;
    time_unit_pulse = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (!prog_a && n < 600) begin tick; n++; end
    n_checks++;
    if (prog_a !== 1'b1) begin n_fail++; $display("FAIL idle_timeout: prog_a=%b expected 1", prog_a); end
  endtask

  task automatic test_reset;
    reset = 1'b1; time_unit_pulse = 1'b0; prog_v = 1'b0; out_a = 1'b0;
    gens_used = 8'd0; gens_en = '0;
    prog_gen_idx = 8'd0; prog_period = 16'd0; prog_ticks = 16'd0; prog_tag = 11'd0;
    tick; tick;
    n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL reset_out_v: got %b expected 0", out_v); end
    n_checks++; if (out_tag !== 11'd0) begin n_fail++; $display("FAIL reset_out_tag: got %h expected 000", out_tag); end
    n_checks++; if (out_ct !== 9'd0) begin n_fail++; $display("FAIL reset_out_ct: got %h expected 000", out_ct); end
    n_checks++; if (missed_unit !== 1'b0) begin n_fail++; $display("FAIL reset_missed: got %b expected 0", missed_unit); end
    n_checks++; if (prog_a !== 1'b0) begin n_fail++; $display("FAIL reset_prog_a_in_reset: got %b expected 0", prog_a); end
    reset = 1'b0;
    #1;
    n_checks++; if (prog_a !== 1'b1) begin n_fail++; $display("FAIL reset_prog_a_after: got %b expected 1", prog_a); end
    tick;
  endtask

  task automatic test_period;
    int exp_n;
    do_reset;
    gens_used = 8'd3; gens_en[3] = 1'b1; out_a = 1'b1;
    prog(8'd3, 16'd4, 16'd0, 11'h155);
    for (int u = 1; u <= 10; u++) begin
      q_tag.delete(); q_ct.delete();
      pulse;
      wait_idle;
      exp_n = (u == 1 || u == 5 || u == 9) ? 1 : 0;
      n_checks++;
      if (q_tag.size() != exp_n) begin n_fail++; $display("FAIL period_count unit %0d: got %0d words expected %0d", u, q_tag.size(), exp_n); end
      if (exp_n == 1 && q_tag.size() == 1) begin
        n_checks++; if (q_tag[0] !== 11'h155) begin n_fail++; $display("FAIL period_tag unit %0d: got %h expected 155", u, q_tag[0]); end
        n_checks++; if (q_ct[0] !== 9'd1) begin n_fail++; $display("FAIL period_ct unit %0d: got %0d expected 1", u, q_ct[0]); end
      end
    end
  endtask

  task automatic setup_three;
    do_reset;
    gens_used = 8'd2; gens_en[2:0] = 3'b111;
    prog(8'd0, 16'd1, 16'd0, 11'h010);
    prog(8'd1, 16'd1, 16'd0, 11'h011);
    prog(8'd2, 16'd1, 16'd0, 11'h012);
  endtask

  task automatic test_order;
    logic [10:0] exp_tag [3];
    exp_tag[0] = 11'h010; exp_tag[1] = 11'h011; exp_tag[2] = 11'h012;
    setup_three;
    out_a = 1'b1;
    pulse;
    n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL order_latency_t1: out_v=%b expected 0", out_v); end
    tick;
    n_checks++; if (out_v !== 1'b1) begin n_fail++; $display("FAIL order_latency_t2: out_v=%b expected 1", out_v); end
    n_checks++; if (out_tag !== 11'h010) begin n_fail++; $display("FAIL order_first_tag: got %h expected 010", out_tag); end
    wait_idle;
    n_checks++;
    if (q_tag.size() != 3) begin n_fail++; $display("FAIL order_count: got %0d expected 3", q_tag.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (q_tag[i] !== exp_tag[i]) begin n_fail++; $display("FAIL order_tag[%0d]: got %h expected %h", i, q_tag[i], exp_tag[i]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] exp_tag [6];
    for (int i = 0; i < 6; i++) exp_tag[i] = 11'h010 + 11'(i % 3);
    setup_three;
    out_a = 1'b0;
    pulse;
    tick;
    for (int c = 1; c <= 5; c++) begin
      n_checks++; if (out_v !== 1'b1) begin n_fail++; $display("FAIL stall_v cycle %0d: got %b expected 1", c, out_v); end
      n_checks++; if (out_tag !== 11'h010) begin n_fail++; $display("FAIL stall_tag cycle %0d: got %h expected 010", c, out_tag); end
      n_checks++; if (out_ct !== 9'd1) begin n_fail++; $display("FAIL stall_ct cycle %0d: got %0d expected 1", c, out_ct); end
      if (c >= 2) begin
        n_checks++;
        if (missed_unit !== (c == 4)) begin n_fail++; $display("FAIL stall_missed cycle %0d: got %b expected %b", c, missed_unit, (c == 4)); end
      end
      time_unit_pulse = (c == 1 || c == 3);
      out_a = (c == 5);
      tick;
    end
    time_unit_pulse = 1'b0;
    wait_idle;
    n_checks++; if (n_missed != 1) begin n_fail++; $display("FAIL stall_missed_total: got %0d expected 1", n_missed); end
    n_checks++;
    if (q_tag.size() != 6) begin n_fail++; $display("FAIL stall_count: got %0d expected 6", q_tag.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (q_tag[i] !== exp_tag[i]) begin n_fail++; $display("FAIL stall_tag_order[%0d]: got %h expected %h", i, q_tag[i], exp_tag[i]); end
      end
    end
  endtask

  task automatic test_inactive;
    do_reset;
    gens_used = 8'd1; gens_en[0] = 1'b1; out_a = 1'b1;
    prog(8'd0, 16'd0, 16'd0, 11'h020);
    prog(8'd1, 16'd2, 16'd1, 11'h021);
    for (int u = 0; u < 6; u++) begin pulse; wait_idle; end
    n_checks++; if (q_tag.size() != 0) begin n_fail++; $display("FAIL inactive_quiet: got %0d words expected 0", q_tag.size()); end
    gens_en[1] = 1'b1;
    pulse; wait_idle;
    n_checks++; if (q_tag.size() != 0) begin n_fail++; $display("FAIL inactive_ticks_kept: got %0d words expected 0", q_tag.size()); end
    pulse; wait_idle;
    n_checks++;
    if (q_tag.size() != 1) begin n_fail++; $display("FAIL inactive_enable_count: got %0d expected 1", q_tag.size()); end
    else if (q_tag[0] !== 11'h021) begin n_fail++; $display("FAIL inactive_enable_tag: got %h expected 021", q_tag[0]); end
  endtask

  task automatic test_prog_stall;
    do_reset;
    gens_used = 8'd0; gens_en[0] = 1'b1; out_a = 1'b0;
    prog(8'd0, 16'd1, 16'd0, 11'h030);
    pulse;
    prog_gen_idx = 8'd0; prog_period = 16'd1; prog_ticks = 16'd0; prog_tag = 11'h031;
    prog_v = 1'b1;
    n_checks++; if (prog_a !== 1'b0) begin n_fail++; $display("FAIL progstall_scan: prog_a=%b expected 0", prog_a); end
    tick; tick;
    n_checks++; if (prog_a !== 1'b0) begin n_fail++; $display("FAIL progstall_emit: prog_a=%b expected 0", prog_a); end
    out_a = 1'b1;
    tick;
    n_checks++; if (prog_a !== 1'b1) begin n_fail++; $display("FAIL progstall_idle: prog_a=%b expected 1", prog_a); end
    tick;
    prog_v = 1'b0;
    n_checks++;
    if (q_tag.size() != 1) begin n_fail++; $display("FAIL progstall_old_count: got %0d expected 1", q_tag.size()); end
    else if (q_tag[0] !== 11'h030) begin n_fail++; $display("FAIL progstall_old_tag: got %h expected 030", q_tag[0]); end
    q_tag.delete(); q_ct.delete();
    pulse; wait_idle;
    n_checks++;
    if (q_tag.size() != 1) begin n_fail++; $display("FAIL progstall_new_count: got %0d expected 1", q_tag.size()); end
    else if (q_tag[0] !== 11'h031) begin n_fail++; $display("FAIL progstall_new_tag: got %h expected 031", q_tag[0]); end
    q_tag.delete(); q_ct.delete();
    prog_tag = 11'h032; prog_v = 1'b1; time_unit_pulse = 1'b1;
    n_checks++; if (prog_a !== 1'b1) begin n_fail++; $display("FAIL samecycle_prog_a: got %b expected 1", prog_a); end
    tick;
    prog_v = 1'b0; time_unit_pulse = 1'b0;
    wait_idle;
    n_checks++;
    if (q_tag.size() != 1) begin n_fail++; $display("FAIL samecycle_count: got %0d expected 1", q_tag.size()); end
    else if (q_tag[0] !== 11'h032) begin n_fail++; $display("FAIL samecycle_tag: got %h expected 032", q_tag[0]); end
  endtask

  task automatic test_reset_emit;
    do_reset;
    gens_used = 8'd0; gens_en[0] = 1'b1; out_a = 1'b0;
    prog(8'd0, 16'd1, 16'd0, 11'h040);
    pulse; tick;
    n_checks++; if (out_v !== 1'b1) begin n_fail++; $display("FAIL rstemit_pre_v: got %b expected 1", out_v); end
    reset = 1'b1;
    tick;
    n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL rstemit_out_v: got %b expected 0", out_v); end
    n_checks++; if (prog_a !== 1'b0) begin n_fail++; $display("FAIL rstemit_prog_a_in_reset: got %b expected 0", prog_a); end
    reset = 1'b0;
    #1;
    n_checks++; if (prog_a !== 1'b1) begin n_fail++; $display("FAIL rstemit_prog_a: got %b expected 1", prog_a); end
    tick;
    gens_used = 8'd255; gens_en = '1; out_a = 1'b1;
    q_tag.delete(); q_ct.delete();
    pulse; wait_idle;
    n_checks++; if (q_tag.size() != 0) begin n_fail++; $display("FAIL rstemit_slots_cleared: got %0d words expected 0", q_tag.size()); end
  endtask

  initial begin
    test_reset;
    test_period;
    test_order;
    test_back_to_back;
    test_inactive;
    test_prog_stall;
    test_reset_emit;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
